// File: rtl/fft_pe_ctrl.sv
// rtl/fft_pe_ctrl.sv - 16-point radix-2 DIF FFT sequencer driving an external butterfly PE
module fft_pe_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] pe_a,
  output logic [31:0] pe_b,
  output logic        pe_ab_valid,
  output logic [2:0]  pe_power,
  input  logic [31:0] pe_fft_a,
  input  logic [31:0] pe_fft_b,
  input  logic        pe_valid,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, OUT} state_t;

  state_t         state;
  logic [1:0]     stage;
  logic [3:0]     load_cnt;
  logic [3:0]     issue_cnt;
  logic [3:0]     result_cnt;
  logic [3:0]     out_cnt;
  logic [2:0]     wr_ptr;
  logic [2:0]     rd_ptr;
  logic [WDW-1:0] wd_cnt;

  logic [31:0] mem    [16];
  logic [3:0]  fifo_a [8];
  logic [3:0]  fifo_b [8];

  logic [2:0] k;
  logic [2:0] mask;
  logic [2:0] idx;
  logic [3:0] span;
  logic [3:0] addr_a;
  logic [3:0] addr_b;
  logic [3:0] wb_a;
  logic [3:0] wb_b;
  logic [3:0] res_next;
  logic       load_fire;
  logic       issue_fire;
  logic       wb_fire;
  logic       out_fire;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Butterfly address generation, handshakes and datapath muxing; PE and output
  // ports are forced to zero whenever their state is not active.
  always_comb begin
    k          = issue_cnt[2:0];
    span       = 4'd8 >> stage;
    mask       = span[2:0] - 3'd1;
    idx        = k & mask;
    // group index lands one bit above the span bit, index stays in the low bits
    addr_a     = {k & ~mask, 1'b0} | {1'b0, idx};
    addr_b     = addr_a + span;
    wb_a       = fifo_a[rd_ptr];
    wb_b       = fifo_b[rd_ptr];
    in_ready   = (state == IDLE) || (state == LOAD);
    load_fire  = in_valid && in_ready;
    issue_fire = (state == ISSUE);
    wb_fire    = pe_valid && ((state == ISSUE) || (state == DRAIN));
    res_next   = result_cnt + {3'b000, wb_fire};
    out_valid  = (state == OUT);
    out_fire   = out_valid && out_ready;
    busy       = (state != IDLE);
    pe_ab_valid = issue_fire;
    pe_a       = issue_fire ? mem[addr_a] : 32'h0;
    pe_b       = issue_fire ? mem[addr_b] : 32'h0;
    pe_power   = issue_fire ? 3'(idx << stage) : 3'd0;
    out_data   = out_valid ? mem[bitrev4(out_cnt)] : 32'h0;
  end

  // Sample memory and pending write-back address FIFO; contents need no reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[load_cnt] <= in_data;
    end
    if (wb_fire) begin
      mem[wb_a] <= pe_fft_a;
      mem[wb_b] <= pe_fft_b;
    end
    if (issue_fire) begin
      fifo_a[wr_ptr] <= addr_a;
      fifo_b[wr_ptr] <= addr_b;
    end
  end

  // Control FSM: load, per-stage issue/drain with watchdog, bit-reversed output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      stage      <= 2'd0;
      load_cnt   <= 4'd0;
      issue_cnt  <= 4'd0;
      result_cnt <= 4'd0;
      out_cnt    <= 4'd0;
      wr_ptr     <= 3'd0;
      rd_ptr     <= 3'd0;
      wd_cnt     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wb_fire) begin
        rd_ptr     <= rd_ptr + 3'd1;
        result_cnt <= res_next;
      end
      if (issue_fire) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      case (state)
        IDLE: begin
          if (load_fire) begin
            state    <= LOAD;
            load_cnt <= 4'd1;
            err      <= 1'b0;
          end
        end
        LOAD: begin
          if (load_fire) begin
            load_cnt <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
              state      <= ISSUE;
              stage      <= 2'd0;
              issue_cnt  <= 4'd0;
              result_cnt <= 4'd0;
            end
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + 4'd1;
          wd_cnt    <= '0;
          if (issue_cnt == 4'd7) begin
            state     <= DRAIN;
            issue_cnt <= 4'd0;
          end
        end
        DRAIN: begin
          if (res_next == 4'd8) begin
            // all write-backs of this stage landed, so the next stage reads fresh data
            result_cnt <= 4'd0;
            wd_cnt     <= '0;
            if (stage == 2'd3) begin
              state   <= OUT;
              out_cnt <= 4'd0;
            end else begin
              stage <= stage + 2'd1;
              state <= ISSUE;
            end
          end else if (wb_fire) begin
            wd_cnt <= '0;
          end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
            err        <= 1'b1;
            state      <= IDLE;
            stage      <= 2'd0;
            load_cnt   <= 4'd0;
            issue_cnt  <= 4'd0;
            result_cnt <= 4'd0;
            out_cnt    <= 4'd0;
            wr_ptr     <= 3'd0;
            rd_ptr     <= 3'd0;
            wd_cnt     <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_fire) begin
            out_cnt <= out_cnt + 4'd1;
            if (out_cnt == 4'd15) begin
              state    <= IDLE;
              out_cnt  <= 4'd0;
              load_cnt <= 4'd0;
              done     <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_pe_ctrl.sv
// tb/tb_fft_pe_ctrl.sv - scoreboard bench for fft_pe_ctrl with a behavioural PE model
module tb_fft_pe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_ready;
  logic [31:0] pe_a, pe_b;
  logic        pe_ab_valid;
  logic [2:0]  pe_power;
  logic [31:0] pe_fft_a = 32'h0;
  logic [31:0] pe_fft_b = 32'h0;
  logic        pe_valid = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b1;
  logic        busy, done, err;

  always #5 clk = ~clk;

  fft_pe_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pe_a(pe_a), .pe_b(pe_b), .pe_ab_valid(pe_ab_valid), .pe_power(pe_power),
    .pe_fft_a(pe_fft_a), .pe_fft_b(pe_fft_b), .pe_valid(pe_valid),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {int a; int b; int p;} iss_t;
  typedef struct {logic [31:0] ra; logic [31:0] rb; int due;} res_t;

  int tab_a   [4][8] = '{'{0,1,2,3,4,5,6,7}, '{0,1,2,3,8,9,10,11},
                         '{0,1,4,5,8,9,12,13}, '{0,2,4,6,8,10,12,14}};
  int tab_pow [4][8] = '{'{0,1,2,3,4,5,6,7}, '{0,2,4,6,0,2,4,6},
                         '{0,4,0,4,0,4,0,4}, '{0,0,0,0,0,0,0,0}};
  int tab_span[4]    = '{8,4,2,1};
  int brev_tab[16]   = '{0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15};

  iss_t        exp_iss[$];
  logic [31:0] exp_out[$];
  res_t        pend[$];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int lat = 3;
  bit drop_mode = 1'b0;
  int pe_res_cnt = 0;
  int n_issue = 0;
  int last_pv_cyc = 0;
  bit rdy_mode = 1'b0;
  bit stalled = 1'b0;
  logic [31:0] held = 32'h0;
  int n_out = 0;
  int done_cnt = 0;
  bit done_prev = 1'b0;
  iss_t e;
  res_t r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got an unexpected event, required none", name);
  endtask

  // PE model: checks each issued butterfly, returns tagged results after lat cycles
  always @(negedge clk) begin
    if (pe_ab_valid) begin
      n_issue++;
      if (exp_iss.size() == 0) fail_now("issue_overrun");
      else begin
        e = exp_iss.pop_front();
        check("pe_a_addr", {16'h0, pe_a[15:0]}, e.a);
        check("pe_b_addr", {16'h0, pe_b[15:0]}, e.b);
        check("pe_power", {29'h0, pe_power}, e.p);
      end
      pend.push_back('{pe_a + 32'h0001_0000, pe_b + 32'h0010_0000, cyc + lat});
    end
    if (pend.size() > 0 && pend[0].due <= cyc && !(drop_mode && pe_res_cnt >= 13)) begin
      r = pend.pop_front();
      pe_valid = 1'b1;
      pe_fft_a = r.ra;
      pe_fft_b = r.rb;
      pe_res_cnt++;
      last_pv_cyc = cyc;
    end else begin
      pe_valid = 1'b0;
      pe_fft_a = 32'h0;
      pe_fft_b = 32'h0;
    end
  end

  // Output monitor: drives out_ready, pops the scoreboard on each accepted output
  always @(negedge clk) begin
    out_ready = rdy_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    if (out_valid) begin
      if (stalled) check("out_stable", out_data, held);
      if (out_ready) begin
        stalled = 1'b0;
        n_out++;
        if (exp_out.size() == 0) fail_now("output_overrun");
        else check("out_data", out_data, exp_out.pop_front());
      end else begin
        stalled = 1'b1;
        held = out_data;
      end
    end else begin
      stalled = 1'b0;
    end
    if (done) begin
      done_cnt++;
      check("done_busy", {31'h0, busy}, 0);
    end
    if (done_prev) check("done_pulse_width", {31'h0, done}, 0);
    done_prev = done;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 1);
    check({tag, "_pe_ab_valid"}, {31'h0, pe_ab_valid}, 0);
    check({tag, "_pe_a"}, pe_a, 0);
    check({tag, "_pe_b"}, pe_b, 0);
    check({tag, "_pe_power"}, {29'h0, pe_power}, 0);
    check({tag, "_out_valid"}, {31'h0, out_valid}, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_busy"}, {31'h0, busy}, 0);
    check({tag, "_done"}, {31'h0, done}, 0);
    check({tag, "_err"}, {31'h0, err}, 0);
  endtask

  task automatic push_schedule(input int nstages);
    for (int s = 0; s < nstages; s++)
      for (int k = 0; k < 8; k++)
        exp_iss.push_back('{tab_a[s][k], tab_a[s][k] + tab_span[s], tab_pow[s][k]});
  endtask

  // PE adds 0x1 (a side) or 0x10 (b side) to the upper half once per stage
  task automatic push_outputs(input logic [15:0] base);
    logic [3:0] nn;
    int o;
    for (int k = 0; k < 16; k++) begin
      nn = 4'(brev_tab[k]);
      o = $countones(nn);
      exp_out.push_back({base + 16'(4 + 15 * o), 12'h0, nn});
    end
  endtask

  task automatic load(input logic [15:0] base, input bit chk_err);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (chk_err && n == 1) check("err_cleared_on_load", {31'h0, err}, 0);
      in_valid = 1'b1;
      in_data = {base, 16'(n)};
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 32'h0;
  endtask

  task automatic run_transform(input int l, input bit rm, input logic [15:0] base);
    int start_done;
    lat = l;
    rdy_mode = rm;
    pe_res_cnt = 0;
    start_done = done_cnt;
    push_schedule(4);
    push_outputs(base);
    n_out = 0;
    load(base, 1'b0);
    for (int i = 0; i < 3000 && done_cnt == start_done; i++) @(negedge clk);
    @(negedge clk);
    check("done_once", done_cnt - start_done, 1);
    check("outputs_count", n_out, 16);
    check("exp_out_drained", exp_out.size(), 0);
    check("schedule_drained", exp_iss.size(), 0);
    check("idle_after_done", {31'h0, busy}, 0);
  endtask

  initial begin
    int err_cyc;
    int base_issue;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    run_transform(3, 1'b0, 16'h0100);
    run_transform(1, 1'b1, 16'h0200);
    run_transform(12, 1'b0, 16'h0300);

    // watchdog: PE stops answering after 5 stage-1 results
    lat = 3;
    rdy_mode = 1'b0;
    drop_mode = 1'b1;
    pe_res_cnt = 0;
    push_schedule(2);
    load(16'h0400, 1'b0);
    err_cyc = 0;
    for (int i = 0; i < 3000 && !err; i++) @(negedge clk);
    err_cyc = cyc;
    check("err_set", {31'h0, err}, 1);
    check("err_latency", err_cyc - last_pv_cyc - 1, 64);
    check("timeout_busy", {31'h0, busy}, 0);
    check("timeout_in_ready", {31'h0, in_ready}, 1);
    check("timeout_schedule", exp_iss.size(), 0);
    drop_mode = 1'b0;
    pend.delete();
    repeat (3) @(negedge clk);
    check("err_sticky", {31'h0, err}, 1);

    // reset in the middle of stage 2 issue
    lat = 3;
    pe_res_cnt = 0;
    base_issue = n_issue;
    push_schedule(4);
    load(16'h0600, 1'b1);
    for (int i = 0; i < 3000 && (n_issue - base_issue) < 19; i++) @(negedge clk);
    check("reached_stage2", {31'h0, pe_ab_valid}, 1);
    #2;
    rst = 1'b0;
    pend.delete();
    exp_iss.delete();
    pe_valid = 1'b0;
    pe_fft_a = 32'h0;
    pe_fft_b = 32'h0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b1;
    @(negedge clk);

    run_transform(3, 1'b1, 16'h0700);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_pe_ctrl.md
FFT_PE_CTRL -- requirements
Module: fft_pe_ctrl

Interface
REQ-001 Parameter TIMEOUT, 64, max cycles the block waits in DRAIN with no pe_valid before aborting.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  input sample valid.
REQ-005 in_data  in  32  input sample {real[15:0], imag[15:0]}, natural order x[0]..x[15].
REQ-006 in_ready  out  1  block accepts in_data this cycle.
REQ-007 pe_a, pe_b  out  32 each  butterfly operands to FFT_PE a/b.
REQ-008 pe_ab_valid  out  1  operand pair valid (drives FFT_PE ab_valid).
REQ-009 pe_power  out  3  twiddle exponent k of W16^k (drives FFT_PE power).
REQ-010 pe_fft_a, pe_fft_b  in  32 each  butterfly results from FFT_PE.
REQ-011 pe_valid  in  1  results valid (from FFT_PE fft_pe_valid); results return in issue order.
REQ-012 out_valid  out  1  output sample valid.
REQ-013 out_data  out  32  output sample, natural order X[0]..X[15].
REQ-014 out_ready  in  1  downstream accepts out_data.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse after X[15] accepted.
REQ-017 err  out  1  sticky timeout flag; cleared only by reset or by the next accepted in_valid in IDLE.

Function
REQ-018 Internal storage: 16x32 sample memory; 8-entry FIFO of pending write-back address pairs.
REQ-019 States: IDLE, LOAD, ISSUE, DRAIN, OUT; 2-bit stage counter s (0..3); 4-bit counters for load/issue/result/output.
REQ-020 in_ready = 1 in IDLE and LOAD, 0 elsewhere; each in_valid&in_ready writes mem[load_cnt], load_cnt++.
REQ-021 IDLE -> LOAD on first accept; LOAD -> ISSUE in cycle after 16th accept, s=0.
REQ-022 Radix-2 DIF schedule: span = 8>>s; butterfly k=0..7: idx = k mod span, grp = k/span, addr_a = 2*span*grp+idx, addr_b = addr_a+span, pe_power = idx<<s.
REQ-023 ISSUE: one butterfly per cycle, pe_ab_valid high exactly 8 consecutive cycles per stage, pe_a=mem[addr_a], pe_b=mem[addr_b], pair pushed to address FIFO same cycle.
REQ-024 Each pe_valid (in ISSUE or DRAIN) pops FIFO, writes pe_fft_a to mem[addr_a], pe_fft_b to mem[addr_b], result_cnt++.
REQ-025 ISSUE -> DRAIN after 8th issue; DRAIN -> ISSUE (s++) when result_cnt reaches 8 and s<3; DRAIN -> OUT when result_cnt reaches 8 and s=3. No next-stage issue before all 8 write-backs (no RAW hazard).
REQ-026 pe_valid in IDLE, LOAD or OUT is ignored; pe_ab_valid, pe_a, pe_b, pe_power are 0 outside ISSUE.
REQ-027 OUT: out_valid=1, out_data = mem[bitrev4(out_cnt)]; out_cnt++ on out_valid&out_ready; out_data held stable while out_ready=0.
REQ-028 After 16th output accept: done=1 next cycle, state IDLE.
REQ-029 DRAIN watchdog: counter reloads on every pe_valid; TIMEOUT consecutive idle cycles -> err=1, FIFO flushed, all counters cleared, state IDLE.
REQ-030 Arithmetic: none in this block; samples passed and stored unmodified, 32 bits.

Reset
REQ-031 rst low asynchronously forces IDLE, all counters/FIFO cleared; outputs: in_ready=1, pe_ab_valid=0, pe_a=pe_b=0, pe_power=0, out_valid=0, out_data=0, busy=0, done=0, err=0.
REQ-032 rst asserted mid-transform abandons it; memory contents undefined, next transform starts fresh with LOAD.

Verification (behavioural PE model, fixed latency L unless stated)
REQ-033 Load x[n]=n, L=3 -> pe_power per stage: s0 0..7; s1 0,2,4,6,0,2,4,6; s2 0,4,0,4,0,4,0,4; s3 all 0; s0 pairs (0,8)..(7,15), s3 pairs (0,1),(2,3)..
REQ-034 Real FFT_PE, impulse x[0]=0x01000000, rest 0 -> all 16 X[k]=0x01000000 (+/-1 LSB), done one pulse.
REQ-035 L=1 and L=12 -> identical outputs; pe_ab_valid never asserted during DRAIN.
REQ-036 out_ready toggled 1,0,0,1 -> out_data stable while stalled, 16 outputs exactly once, order X[0]..X[15].
REQ-037 PE model drops pe_valid after 5 results in stage 1 -> err=1 exactly TIMEOUT=64 cycles after last pe_valid, busy=0, in_ready=1.
REQ-038 rst low during ISSUE of stage 2 -> next cycle all outputs at REQ-031 values; subsequent full transform correct.
